// File: rtl/sample_rate_divider_pkg.sv
// Shared sniffer constants: default probe/divider widths, core clock rate, counter op codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sample_rate_divider_pkg;

    // Default width of a captured probe word.
    localparam int SNIFFER_DATA_WIDTH = 32;

    // Default width of the divider register and its down-counter.
    localparam int SNIFFER_DIV_WIDTH  = 24;

    // Core clock frequency feeding the whole sniffer.
    localparam int CORE_CLK_HZ        = 100_000_000;

    // Operation applied to the reload down-counter in a given cycle.
    //   CNT_HOLD   : nothing changes
    //   CNT_LOAD   : new divisor captured, count restarts from zero
    //   CNT_RELOAD : sample taken, count reloaded from the divisor
    //   CNT_DEC    : valid word consumed mid-period, count steps down
    typedef enum logic [1:0] {
        CNT_HOLD   = 2'd0,
        CNT_LOAD   = 2'd1,
        CNT_RELOAD = 2'd2,
        CNT_DEC    = 2'd3
    } cnt_op_e;

endpackage : sample_rate_divider_pkg

// File: rtl/sample_rate_divider_reload_down_counter.sv
// Divisor register plus saturating down-counter with load/reload/decrement and zero flag.
// Latency: one clock from op to updated count/divisor.
// Backpressure: none; the op input is acted on every cycle.
module reload_down_counter
    import sample_rate_divider_pkg::*;
#(
    parameter int WIDTH = SNIFFER_DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  cnt_op_e          op,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] div_reg,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             half_hit
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Value the count takes on a decrement; only used when count is non-zero.
    logic [WIDTH-1:0] count_dec;

    // Zero flag, decremented value and "next decrement lands on the half point" flag.
    always_comb begin
        zero      = (count == '0);
        count_dec = count - ONE;
        half_hit  = (count_dec == (div_reg >> 1));
    end

    // Divisor and counter state; the count never wraps below zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_reg <= '0;
            count   <= '0;
        end else begin
            case (op)
                CNT_LOAD: begin
                    div_reg <= load_value;
                    count   <= '0;
                end
                CNT_RELOAD: begin
                    count <= div_reg;
                end
                CNT_DEC: begin
                    if (!zero) begin
                        count <= count_dec;
                    end
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

endmodule : reload_down_counter

// File: rtl/sample_rate_divider.sv
// Decimates a probe stream: keeps one valid word out of every (divisor+1), with a ~50% duty marker.
// Latency: one clock from in_data to sample_data/sample_valid.
// Backpressure: none; in_valid words are always accepted, decimation is only the sample_valid enable.
module sample_rate_divider
    import sample_rate_divider_pkg::*;
#(
    parameter int DATA_WIDTH = SNIFFER_DATA_WIDTH,
    parameter int DIV_WIDTH  = SNIFFER_DIV_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_divider,
    input  logic [DIV_WIDTH-1:0]  divider_in,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  sample_valid,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  ready50
);

    cnt_op_e              cnt_op;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] count;
    logic                 cnt_zero;
    logic                 cnt_half_hit;

    reload_down_counter #(
        .WIDTH (DIV_WIDTH)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .op         (cnt_op),
        .load_value (divider_in),
        .div_reg    (div_reg),
        .count      (count),
        .zero       (cnt_zero),
        .half_hit   (cnt_half_hit)
    );

    // Choose this cycle's counter op: a divisor load aborts any period in flight
    // and swallows a coincident valid word; otherwise a valid word either samples
    // (count exhausted) or steps the count down.
    always_comb begin
        cnt_op = CNT_HOLD;
        if (set_divider) begin
            cnt_op = CNT_LOAD;
        end else if (in_valid) begin
            cnt_op = cnt_zero ? CNT_RELOAD : CNT_DEC;
        end
    end

    // Output strobe, held sample word and duty marker, driven from the chosen op.
    always_ff @(posedge clock) begin
        if (reset) begin
            sample_valid <= 1'b0;
            sample_data  <= '0;
            ready50      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (cnt_op)
                CNT_LOAD: begin
                    ready50 <= 1'b0;
                end
                CNT_RELOAD: begin
                    sample_valid <= 1'b1;
                    sample_data  <= in_data;
                    // With divide-by-1 there is no mid-period drop point, so the
                    // marker toggles per sample instead to keep ~50% duty.
                    ready50      <= (div_reg != '0) ? 1'b1 : ~ready50;
                end
                CNT_DEC: begin
                    if (cnt_half_hit) begin
                        ready50 <= 1'b0;
                    end
                end
                default: begin
                    ready50 <= ready50;
                end
            endcase
        end
    end

    // Counter value is only observed through the zero/half flags at this level.
    logic unused_count;
    assign unused_count = ^count;

endmodule : sample_rate_divider

// File: tb/tb_sample_rate_divider.sv
// Self-checking bench for sample_rate_divider: directed scenarios plus randomized traffic.
// Latency: outputs compared one clock after the inputs that produced them.
// Backpressure: n/a.
module tb_sample_rate_divider;

    localparam int DW = 32;
    localparam int VW = 24;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          set_divider = 1'b0;
    logic [VW-1:0] divider_in = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          ready50;

    int checks   = 0;
    int failures = 0;

    sample_rate_divider #(
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (VW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .set_divider  (set_divider),
        .divider_in   (divider_in),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .ready50      (ready50)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: a period is (div+1) valid words; the first valid word
    // after reset/load is always kept; the marker drops once the number of words
    // consumed since the last sample reaches div - floor(div/2).
    longint        m_div;
    longint        m_phase;
    bit            m_fresh;
    bit            m_on = 1'b0;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_ready;

    always @(posedge clock) begin
        if (reset) begin
            m_div   = 0;
            m_phase = 0;
            m_fresh = 1'b1;
            e_valid = 1'b0;
            e_data  = '0;
            e_ready = 1'b0;
        end else if (set_divider) begin
            m_div   = longint'(divider_in);
            m_fresh = 1'b1;
            m_phase = 0;
            e_valid = 1'b0;
            e_ready = 1'b0;
        end else if (in_valid) begin
            if (m_fresh || m_phase == m_div) begin
                e_valid = 1'b1;
                e_data  = in_data;
                m_phase = 0;
                m_fresh = 1'b0;
                e_ready = (m_div != 0) ? 1'b1 : ~e_ready;
            end else begin
                e_valid = 1'b0;
                m_phase = m_phase + 1;
                if (m_phase == m_div - (m_div / 2)) e_ready = 1'b0;
            end
        end else begin
            e_valid = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (m_on) begin
            check("model_sample_valid", 64'(sample_valid), 64'(e_valid));
            check("model_sample_data",  64'(sample_data),  64'(e_data));
            check("model_ready50",      64'(ready50),      64'(e_ready));
        end
    end

    task automatic step(input logic sd, input logic [VW-1:0] dv, input logic iv, input logic [DW-1:0] id);
        set_divider = sd;
        divider_in  = dv;
        in_valid    = iv;
        in_data     = id;
        @(posedge clock);
        #1;
    endtask

    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_list[3];

    initial begin
        // Reset state.
        reset = 1'b1;
        step(0, 0, 1, 32'hDEAD);
        m_on = 1'b1;
        step(1, 24'h7, 1, 32'hBEEF);
        reset = 1'b0;
        check("reset_valid", 64'(sample_valid), 64'd0);
        check("reset_data",  64'(sample_data),  64'd0);
        check("reset_ready", 64'(ready50),      64'd0);

        // Divide-by-1 after reset: every word passes, marker toggles.
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, DW'(i));
            check("div1_valid", 64'(sample_valid), 64'd1);
            check("div1_data",  64'(sample_data),  64'(i));
            check("div1_ready", 64'(ready50),      64'((i % 2) == 0));
        end

        // Divisor 3: samples 0x10,0x14,0x18; marker high 2, low 2.
        step(1, 3, 0, 0);
        got.delete();
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, DW'(32'h10 + i));
            check("div4_ready", 64'(ready50), 64'((i % 4) < 2));
            if (sample_valid) got.push_back(sample_data);
        end
        exp_list = '{32'h10, 32'h14, 32'h18};
        check("div4_count", 64'(got.size()), 64'd3);
        for (int k = 0; k < 3; k++)
            check("div4_sample", 64'((k < got.size()) ? got[k] : '1), 64'(exp_list[k]));

        // Divisor 2 with alternating valid: every 3rd valid word kept.
        step(1, 2, 0, 0);
        got.delete();
        for (int i = 0; i < 18; i++) begin
            step(0, 0, ((i % 2) == 0), DW'(i));
            if (sample_valid) got.push_back(sample_data);
        end
        exp_list = '{32'd0, 32'd6, 32'd12};
        check("alt_count", 64'(got.size()), 64'd3);
        for (int k = 0; k < 3; k++)
            check("alt_sample", 64'((k < got.size()) ? got[k] : '1), 64'(exp_list[k]));

        // Load coincident with a valid word at count zero: no sample, next word kept.
        step(1, 4, 0, 0);
        step(1, 4, 1, 32'hAA);
        check("coinc_novalid", 64'(sample_valid), 64'd0);
        check("coinc_hold",    64'(sample_data),  64'd12);
        step(0, 0, 1, 32'hBB);
        check("coinc_valid", 64'(sample_valid), 64'd1);
        check("coinc_data",  64'(sample_data),  64'hBB);

        // Maximum divisor, then reset mid-period.
        step(1, 24'hFFFFFF, 0, 0);
        step(0, 0, 1, 32'h1);
        check("max_first", 64'(sample_data), 64'h1);
        step(0, 0, 1, 32'h2);
        step(0, 0, 1, 32'h3);
        check("max_nosample", 64'(sample_valid), 64'd0);
        check("max_ready",    64'(ready50),      64'd1);
        reset = 1'b1;
        step(1, 5, 1, 32'h55);
        reset = 1'b0;
        check("midrst_valid", 64'(sample_valid), 64'd0);
        check("midrst_data",  64'(sample_data),  64'd0);
        check("midrst_ready", 64'(ready50),      64'd0);
        step(0, 0, 1, 32'h77);
        check("postrst_data1", 64'(sample_data), 64'h77);
        check("postrst_ready1", 64'(ready50), 64'd1);
        step(0, 0, 1, 32'h78);
        check("postrst_valid2", 64'(sample_valid), 64'd1);
        check("postrst_data2",  64'(sample_data),  64'h78);

        // Divisor 5 aborted after two decrements by divisor 1.
        step(1, 5, 0, 0);
        step(0, 0, 1, 32'h30);
        step(0, 0, 1, 32'h31);
        step(0, 0, 1, 32'h32);
        step(1, 1, 1, 32'h33);
        check("abort_novalid", 64'(sample_valid), 64'd0);
        check("abort_hold",    64'(sample_data),  64'h30);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, DW'(32'h40 + i));
            check("abort_valid", 64'(sample_valid), 64'((i % 2) == 0));
            check("abort_ready", 64'(ready50),      64'((i % 2) == 0));
            if ((i % 2) == 0) check("abort_data", 64'(sample_data), 64'(32'h40 + i));
        end

        // Randomized traffic checked by the model alone.
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            logic [VW-1:0] dv;
            r = $urandom_range(0, 199);
            reset = (r == 0);
            dv = ($urandom_range(0, 7) == 0) ? VW'($urandom) : VW'($urandom_range(0, 6));
            step((r < 8), dv, ($urandom_range(0, 3) != 0), $urandom);
        end
        reset = 1'b0;
        step(0, 0, 0, 0);

        m_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sample_rate_divider

// File: doc/sample_rate_divider.md
SAMPLE_RATE_DIVIDER -- requirements
Module: sample_rate_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the captured probe word.
REQ-002 SHALL have parameter DIV_WIDTH, default 24: width of the divider register and down-counter.
REQ-003 SHALL have port clock  input  1: 100 MHz core clock; all logic on its rising edge; no other clock.
REQ-004 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port set_divider  input  1: single-cycle load strobe for divider_in.
REQ-006 SHALL have port divider_in  input  DIV_WIDTH: sample divisor minus one.
REQ-007 SHALL have port in_valid  input  1: in_data is a valid probe word this cycle.
REQ-008 SHALL have port in_data  input  DATA_WIDTH: raw probe word.
REQ-009 SHALL have port sample_valid  output  1: single-cycle strobe marking a decimated sample.
REQ-010 SHALL have port sample_data  output  DATA_WIDTH: decimated sample, held between strobes.
REQ-011 SHALL have port ready50  output  1: approx. 50% duty marker of the sample period.

Function
REQ-012 SHALL hold div_reg (DIV_WIDTH) and counter (DIV_WIDTH), both registered.
REQ-013 SHALL, on set_divider=1, load div_reg<=divider_in and counter<=0, force sample_valid<=0, hold sample_data, force ready50<=0; in_valid ignored that cycle.
REQ-014 SHALL, on in_valid=1 with counter==0 (no set_divider), set sample_valid<=1, sample_data<=in_data, counter<=div_reg.
REQ-015 SHALL, on in_valid=1 with counter!=0, set counter<=counter-1 and sample_valid<=0.
REQ-016 SHALL, on in_valid=0, hold counter, sample_data and ready50, with sample_valid<=0.
REQ-017 SHALL yield exactly one sample per (div_reg+1) valid input words; latency in_data->sample_data 1 clock.
REQ-018 SHALL capture the first valid word after reset or set_divider (counter starts at 0).
REQ-019 SHALL, on each sample event, set ready50<=1 if div_reg!=0, else ready50<=~ready50.
REQ-020 SHALL, on a decrement cycle where counter-1 == div_reg>>1 (logical shift), set ready50<=0.
REQ-021 SHALL use unsigned arithmetic; counter never decrements below 0 (no wrap); div_reg = 2^DIV_WIDTH-1 is legal.
REQ-022 SHALL treat set_divider mid-period as an abort: current period discarded, new divisor effective from the next in_valid.

Reset
REQ-023 SHALL, while reset=1, drive div_reg=0, counter=0, sample_valid=0, sample_data=0, ready50=0 at the next edge.
REQ-024 SHALL give reset priority over set_divider and in_valid.
REQ-025 SHALL, after reset with no set_divider, pass every valid word (divide-by-1).

Structure
REQ-026 SHALL take DATA_WIDTH and DIV_WIDTH defaults from the shared sniffer constants package, alongside the core clock frequency constant (100 MHz).
REQ-027 SHALL place the counter/reload logic in one sub-module, reload_down_counter (load, reload, decrement-when-enabled, zero flag).
REQ-028 SHALL contain no clock gating, no derived clocks; decimation expressed only as the sample_valid enable.

Verification
REQ-029 SHALL cover: reset, no set_divider, in_valid=1 continuous, in_data=0,1,2,... -> sample_valid every cycle, sample_data=0,1,2 one cycle late, ready50 toggling.
REQ-030 SHALL cover: set_divider with divider_in=3, in_valid=1 continuous, in_data counting from 0x10 -> samples 0x10,0x14,0x18; ready50 high 2 cycles, low 2 cycles.
REQ-031 SHALL cover: divider 2, in_valid pattern 1,0,1,0,1,0... -> samples every 3rd valid word; counter/sample_data held on in_valid=0 cycles.
REQ-032 SHALL cover: divider 4, set_divider=1 coincident with in_valid=1 and counter==0 -> no sample that cycle; next valid word sampled.
REQ-033 SHALL cover: divider 0xFFFFFF, force reset mid-period -> all outputs 0 next cycle, div_reg=0, next valid word sampled immediately.
REQ-034 SHALL cover: divider 5, set_divider with divider_in=1 issued after two decrements -> period restarts, then sample every 2nd valid word.
